// File: rtl/cache_pkg.sv
// cache_pkg: geometry constants, address field helpers and controller state type
// for the 4 KiB direct-mapped read-only cache.
package cache_pkg;
    localparam int SETS       = 64;
    localparam int LINE_BYTES = 64;
    localparam int LINE_WORDS = LINE_BYTES / 8;
    localparam int INDEX_W    = $clog2(SETS);
    localparam int OFFSET_W   = $clog2(LINE_BYTES);
    localparam int TAG_W      = 64 - INDEX_W - OFFSET_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP, FLUSH} state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [63:0] a);
        return a[63 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [63:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [63:0] a);
        return {a[OFFSET_W-1:3], 3'b000};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return &x ? x : x + 32'd1;
    endfunction
endpackage

// File: rtl/cache_tag_array.sv
// cache_tag_array: per-line valid bits and tags with a one-cycle clear-all,
// a combinational hit compare and a single write port sharing the index.
module cache_tag_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    output logic               hit,
    input  logic               we,
    input  logic               wr_valid
);
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];

    assign hit = valid[index] && tags[index] == tag;

    always_ff @(posedge clk) begin
        if (rst || clr)
            valid <= '0;
        else if (we)
            valid[index] <= wr_valid;
    end

    always_ff @(posedge clk) begin
        if (we)
            tags[index] <= tag;
    end
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: lookup / refill sequencer for a direct-mapped read-only cache,
// driving the external data RAM and returning one doubleword per load.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [63:0]         req_addr,
    output logic                resp_valid,
    output logic [63:0]         resp_data,
    input  logic                flush,
    output logic                flush_done,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [63:0]         mem_req_addr,
    input  logic                mem_rvalid,
    input  logic [63:0]         mem_rdata,
    output logic                ram_wen,
    output logic [INDEX_W-1:0]  ram_index,
    output logic [OFFSET_W-1:0] ram_offset,
    output logic [63:0]         ram_wdata,
    input  logic [63:0]         ram_rdata,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
);
    state_t      state;
    logic [63:0] addr_q;
    logic [2:0]  beat;
    logic        hit;
    logic        last_beat;

    assign last_beat = state == REFILL && mem_rvalid && beat == 3'(LINE_WORDS - 1);

    // A miss invalidates the line up front; the final beat revalidates it with the new tag.
    cache_tag_array u_tags (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == FLUSH),
        .index    (addr_index(addr_q)),
        .tag      (addr_tag(addr_q)),
        .hit      (hit),
        .we       ((state == LOOKUP && !hit) || last_beat),
        .wr_valid (state == REFILL)
    );

    always_comb begin
        req_ready     = state == IDLE && !flush && !rst;
        resp_valid    = state == RESP;
        flush_done    = state == FLUSH;
        mem_req_valid = state == MISS_REQ;
        mem_req_addr  = {addr_q[63:OFFSET_W], {OFFSET_W{1'b0}}};
        ram_wen       = state == REFILL && mem_rvalid;
        ram_wdata     = mem_rdata;
        ram_index     = state == IDLE ? addr_index(req_addr) : addr_index(addr_q);
        ram_offset    = state == IDLE   ? addr_offset(req_addr) :
                        state == REFILL ? {beat, 3'b000} : addr_offset(addr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            beat      <= '0;
            resp_data <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush)
                        state <= FLUSH;
                    else if (req_valid) begin
                        addr_q <= {req_addr[63:3], 3'b000};
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_data <= ram_rdata;
                        hit_cnt   <= sat_inc(hit_cnt);
                        state     <= RESP;
                    end else begin
                        miss_cnt <= sat_inc(miss_cnt);
                        state    <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        beat  <= '0;
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        if (beat == addr_q[5:3])
                            resp_data <= mem_rdata;
                        beat <= beat + 3'd1;
                        if (last_beat)
                            state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: randomized load/flush/reset traffic checked against a
// line-level cache model with its own memory and data-RAM models.
module tb_cache_ctrl;
    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        flush = 0;
    logic        flush_done;
    logic        mem_req_valid;
    logic        mem_req_ready = 0;
    logic [63:0] mem_req_addr;
    logic        mem_rvalid = 0;
    logic [63:0] mem_rdata = '0;
    logic        ram_wen;
    logic [5:0]  ram_index;
    logic [5:0]  ram_offset;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    bit          m_valid [64];
    logic [51:0] m_tag   [64];
    logic [63:0] m_data  [64][8];
    int          m_hits, m_misses;

    logic [63:0] bram [512];
    logic [5:0]  wr_offs [$];

    cache_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush), .flush_done(flush_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ram_wen(ram_wen), .ram_index(ram_index),
        .ram_offset(ram_offset), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous data RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_wen) begin
            bram[{ram_index, ram_offset[5:3]}] <= ram_wdata;
            wr_offs.push_back(ram_offset);
        end
        ram_rdata <= bram[{ram_index, ram_offset[5:3]}];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_valid[i]) m_valid[i] = 0;
    endtask

    task automatic do_load(input logic [63:0] a, input int stall, input bit dir);
        logic [63:0] line [8];
        logic [5:0]  idx;
        int          w, cyc, mreq, beats, last_cyc;
        bit          exp_hit, refill, acc, got, ok;
        idx = a[11:6];
        w = int'(a[5:3]);
        exp_hit = m_valid[idx] && m_tag[idx] == a[63:12];
        for (int k = 0; k < 8; k++) line[k] = dir ? 64'hA0 + 64'(k) : {$urandom, $urandom};
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        wr_offs.delete();
        req_valid = 1;
        req_addr = a;
        cyc = 0; mreq = 0; beats = 0; last_cyc = 0; refill = 0; acc = 0; got = 0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            req_valid = 0;
            req_addr = {$urandom, $urandom};
            if (resp_valid) begin
                got = 1;
                check("resp_data", resp_data, exp_hit ? m_data[idx][w] : line[w]);
                check("resp_latency", 64'(cyc), exp_hit ? 64'd2 : 64'(last_cyc + 1));
            end
            mem_rvalid = 0;
            if (acc) begin
                acc = 0;
                refill = 1;
                mem_req_ready = 0;
            end
            if (refill) begin
                if (beats < 8 && $urandom_range(0, 3) != 0) begin
                    mem_rvalid = 1;
                    mem_rdata = line[beats];
                    beats++;
                    if (beats == 8) last_cyc = cyc;
                end
            end else begin
                // Stray beats outside a refill must be ignored.
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata = {$urandom, $urandom};
                if (mem_req_valid) begin
                    mreq++;
                    check("mem_req_addr", mem_req_addr, {a[63:6], 6'b0});
                    if (mreq > stall) begin
                        mem_req_ready = 1;
                        acc = 1;
                    end
                end
            end
        end
        mem_rvalid = 0;
        mem_req_ready = 0;
        if (!got) check("resp_timeout", 0, 1);
        check("mem_req_cycles", 64'(mreq), exp_hit ? 64'd0 : 64'(stall + 1));
        ok = wr_offs.size() == (exp_hit ? 0 : 8);
        foreach (wr_offs[k]) ok &= wr_offs[k] == 6'(k * 8);
        check("ram_writes", 64'(ok), 1);
        if (exp_hit) m_hits++;
        else begin
            m_misses++;
            m_valid[idx] = 1;
            m_tag[idx] = a[63:12];
            for (int k = 0; k < 8; k++) m_data[idx][k] = line[k];
        end
        check("hit_cnt", 64'(hit_cnt), 64'(m_hits));
        check("miss_cnt", 64'(miss_cnt), 64'(m_misses));
        @(negedge clk);
        check("resp_pulse", 64'(resp_valid), 0);
    endtask

    task automatic do_flush();
        int pulses;
        flush = 1;
        #1 check("ready_during_flush", 64'(req_ready), 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (flush_done) begin
                pulses++;
                flush = 0;
            end
        end
        flush = 0;
        check("flush_done_pulses", 64'(pulses), 1);
        model_clear();
    endtask

    initial begin
        model_clear();
        m_hits = 0;
        m_misses = 0;
        repeat (2) @(negedge clk);
        check("ready_in_reset", 64'(req_ready), 0);
        rst = 0;
        #1;
        check("ready_after_reset", 64'(req_ready), 1);
        check("reset_outputs", {resp_valid, flush_done, mem_req_valid, ram_wen}, 0);
        check("reset_resp_data", resp_data, 0);
        check("reset_counters", {hit_cnt, miss_cnt}, 0);

        do_load(64'h1000_0048, 0, 1);
        do_load(64'h1000_0078, 0, 1);
        do_load(64'h2000_0040, 0, 1);
        do_load(64'h1000_0048, 0, 1);
        do_load(64'h3000_0100, 5, 0);
        do_flush();
        do_load(64'h3000_0100, 0, 0);

        // Reset in the middle of a refill, after beat 3 has been written.
        @(negedge clk);
        req_valid = 1;
        req_addr = 64'h1000_0048;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        check("midrst_mem_req", 64'(mem_req_valid), 1);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1;
            mem_rdata = 64'hB0 + 64'(k);
            @(negedge clk);
        end
        mem_rvalid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        check("midrst_ready", 64'(req_ready), 1);
        check("midrst_counters", {hit_cnt, miss_cnt}, 0);
        check("midrst_resp_valid", 64'(resp_valid), 0);
        model_clear();
        m_hits = 0;
        m_misses = 0;
        do_load(64'h1000_0048, 0, 0);
        do_load(64'h1000_0050, 0, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) do_flush();
            do_load((64'($urandom_range(1, 3)) << 12) | (64'($urandom_range(0, 3)) << 6) |
                    (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7)),
                    $urandom_range(0, 3), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the 4 KiB direct-mapped cache data RAM: 64 lines × 64 B.
- Owns the valid bits and tag array; performs the lookup.
- On a miss, issues a line refill to memory and writes the 8 returned 64-bit beats into the data RAM.
- Returns the requested doubleword to the CPU load port. Read-only cache (instruction / load path); no dirty state.

Parameters:
- SETS, 64, number of lines; index width = log2(SETS) = 6
- LINE_BYTES, 64, line size; offset width 6; LINE_WORDS = LINE_BYTES/8 = 8
- TAG_W, 52, tag width = 64 - 6 - 6

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU load request
- req_ready  out  1  controller can accept a request (IDLE and no flush)
- req_addr  in  64  byte address; bits [2:0] ignored (treated as 0)
- resp_valid  out  1  one-cycle pulse, load data valid
- resp_data  out  64  load data
- flush  in  1  invalidate all lines
- flush_done  out  1  one-cycle pulse
- mem_req_valid  out  1  refill request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  64  line-aligned address {tag,index,6'b0}
- mem_rvalid  in  1  refill beat valid
- mem_rdata  in  64  refill beat, beats in ascending word order 0..7
- ram_wen  out  1  data RAM write enable
- ram_index  out  6  data RAM line select
- ram_offset  out  6  data RAM byte offset, always 8-aligned
- ram_wdata  out  64  data RAM write data
- ram_rdata  in  64  data RAM read data, 1-cycle synchronous read latency
- hit_cnt  out  32  saturating hit counter
- miss_cnt  out  32  saturating miss counter

Behaviour:
- Reset values:
  - state IDLE; all valid bits 0; hit_cnt = 0, miss_cnt = 0.
  - req_ready 0 during the reset cycle, 1 the cycle after.
  - resp_valid, flush_done, mem_req_valid, ram_wen all 0; resp_data 0.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP, FLUSH.
- IDLE:
  - req_ready = !flush. flush has priority over req_valid.
  - On req_valid & req_ready: latch the address into addr_q; drive ram_index/ram_offset combinationally from req_addr; go to LOOKUP.
  - On flush: go to FLUSH.
- LOOKUP (cycle T+1):
  - hit = valid[idx] & (tags[idx] == tag_q).
  - On hit: resp_data <= ram_rdata; hit_cnt++; go to RESP.
  - On miss: miss_cnt++; go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid = 1, mem_req_addr stable until the cycle mem_req_ready = 1.
  - Clear valid[idx] on entry, so a reset-free abort cannot leave a stale line valid.
  - Then beat counter = 0; go to REFILL.
- REFILL:
  - Each mem_rvalid cycle: ram_wen = 1, ram_index = idx_q, ram_offset = {beat,3'b000}, ram_wdata = mem_rdata.
  - If beat == addr_q[5:3], capture mem_rdata into resp_data.
  - beat++. On the beat-7 write: tags[idx] <= tag_q, valid[idx] <= 1, go to RESP.
  - No end-of-burst signal exists; the controller counts exactly 8 beats.
- RESP: resp_valid = 1 for exactly one cycle; go to IDLE. No backpressure.
- FLUSH: all valid bits cleared in one cycle; flush_done pulses; go to IDLE.
- Latency (accept cycle = T):
  - Hit: resp_valid at T+2.
  - Miss: resp_valid one cycle after the 8th beat.
  - Back-to-back hits give a throughput of one request per 3 cycles.
- Counters saturate at 32'hFFFF_FFFF; no wrap.
- mem_rvalid outside REFILL is ignored.
- flush asserted while not IDLE is held off until IDLE; it is level-sensitive and must be held by the requester.
- rst mid-refill: immediate return to IDLE. All valid bits are cleared, so a partially written line is never hit. The memory side is reset by the same rst, so no in-flight beats survive.
- ram_wen is 0 in every state except REFILL beat cycles.

Decomposition:
- Shared package cache_pkg:
  - SETS, LINE_BYTES, TAG_W, INDEX_W, OFFSET_W constants.
  - Address field slice helpers (tag/index/offset extraction).
  - State enum type.
- One natural sub-module: cache_tag_array, holding valid + tag storage with a single-cycle clear-all, a read compare port and a write port. The FSM and counters stay in cache_ctrl.

Test Plan:
- Cold miss:
  - Stimulus: after reset, load 0x1000_0048; mem_req_ready = 1 immediately; beats k = 0..7 return 0xA0+k.
  - Required: mem_req_addr = 0x1000_0040; eight ram writes at offsets 0x00..0x38; resp_data = 0xA1; miss_cnt = 1.
- Hit:
  - Stimulus: then load 0x1000_0078.
  - Required: no mem_req_valid; resp_valid at T+2 with data 0xA7; hit_cnt = 1.
- Conflict miss:
  - Stimulus: load 0x2000_0040 (same index 1, different tag); then reload 0x1000_0048.
  - Required: both loads miss; the second triggers a refill; miss_cnt = 3.
- Stall and flush:
  - Stimulus: hold mem_req_ready = 0 for 5 cycles on a miss, then complete the refill; then assert flush and re-access the same address.
  - Required: mem_req_valid and mem_req_addr stable for all 5 cycles; flush_done pulses once; the re-access misses.
- Reset mid-refill:
  - Stimulus: assert rst after beat 3.
  - Required: next cycle state IDLE, req_ready = 1, counters = 0; a subsequent load to the same line misses.
